// File: rtl/flit_sender.sv
// Drain side of a router input FIFO: pops flits and decodes XY routes from headers.
// Forwards each wormhole packet on its locked output port with a valid/ack handshake.
module flit_sender #(
    parameter int unsigned MY_X = 0,
    parameter int unsigned MY_Y = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic [7:0] out_data,
    output logic       loc_valid,
    input  logic       loc_ack,
    output logic       x_valid,
    input  logic       x_ack,
    output logic       y_valid,
    input  logic       y_ack,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND
    } state_t;

    typedef enum logic [1:0] {
        RT_NONE,
        RT_LOC,
        RT_X,
        RT_Y
    } route_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_in_pkt;
    logic       w_in_pkt_nxt;
    logic [2:0] r_rem;
    logic [2:0] w_rem_nxt;
    route_t     r_route;
    route_t     w_route_nxt;
    logic [7:0] r_out_data;
    logic [7:0] w_out_data_nxt;
    route_t     w_dec_route;
    logic       w_ack_sel;

    // XY routing: resolve the x dimension first, then y, else deliver locally.
    always_comb begin
        w_dec_route = RT_LOC;
        if (fifo_data[1] != MY_X[0]) begin
            w_dec_route = RT_X;
        end else if (fifo_data[0] != MY_Y[0]) begin
            w_dec_route = RT_Y;
        end
    end

    always_comb begin
        w_ack_sel = 1'b0;
        case (r_route)
            RT_LOC:  w_ack_sel = loc_ack;
            RT_X:    w_ack_sel = x_ack;
            RT_Y:    w_ack_sel = y_ack;
            default: w_ack_sel = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_pkt_nxt   = r_in_pkt;
        w_rem_nxt      = r_rem;
        w_route_nxt    = r_route;
        w_out_data_nxt = r_out_data;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_out_data_nxt = fifo_data;
                if (r_in_pkt) begin
                    w_state_nxt = S_SEND;
                end else if (fifo_data[7]) begin
                    w_route_nxt  = w_dec_route;
                    w_rem_nxt    = fifo_data[6:4];
                    w_in_pkt_nxt = 1'b1;
                    w_state_nxt  = S_SEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (w_ack_sel) begin
                    if (r_rem == 3'd0) begin
                        w_in_pkt_nxt = 1'b0;
                        w_route_nxt  = RT_NONE;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_rem_nxt   = r_rem - 3'd1;
                        w_state_nxt = fifo_empty ? S_IDLE : S_RD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_pkt   <= 1'b0;
            r_rem      <= '0;
            r_route    <= RT_NONE;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_pkt   <= w_in_pkt_nxt;
            r_rem      <= w_rem_nxt;
            r_route    <= w_route_nxt;
            r_out_data <= w_out_data_nxt;
        end
    end

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    assign fifo_rd   = (r_state == S_RD);
    assign loc_valid = (r_state == S_SEND) && (r_route == RT_LOC);
    assign x_valid   = (r_state == S_SEND) && (r_route == RT_X);
    assign y_valid   = (r_state == S_SEND) && (r_route == RT_Y);
    assign out_data  = r_out_data;
    assign busy      = r_in_pkt;
    assign drop      = (r_state == S_CAP) && !r_in_pkt && !fifo_data[7];

endmodule

// File: tb/tb_flit_sender.sv
// Scoreboard bench for flit_sender: a queue-backed FIFO model feeds flits, and
// expected {port, flit} pairs are compared as the DUT hands them off or drops them.
module tb_flit_sender;

    localparam bit TB_X = 1'b0;
    localparam bit TB_Y = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic [7:0] out_data;
    logic       loc_valid, loc_ack;
    logic       x_valid, x_ack;
    logic       y_valid, y_ack;
    logic       busy;
    logic       drop;

    flit_sender #(.MY_X(0), .MY_Y(0)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
        .out_data(out_data),
        .loc_valid(loc_valid), .loc_ack(loc_ack),
        .x_valid(x_valid), .x_ack(x_ack),
        .y_valid(y_valid), .y_ack(y_ack),
        .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [7:0]  fq[$];
    logic [9:0]  exq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // port codes: 0 = dropped, 1 = local, 2 = x, 3 = y
    function automatic logic [1:0] rt(input logic [7:0] h);
        if (h[1] != TB_X) return 2'd2;
        if (h[0] != TB_Y) return 2'd3;
        return 2'd1;
    endfunction

    task automatic push(input logic [1:0] port, input logic [7:0] d);
        fq.push_back(d);
        exq.push_back({port, d});
        fifo_empty = 1'b0;
    endtask

    // Monitor and FIFO model share one negedge process so their ordering is fixed.
    int unsigned cyc = 0;
    int unsigned rd_cyc = 0;
    int          nv;
    logic [1:0]  port, prev_port = 2'd0;
    logic        acked, prev_acked = 1'b0, prev_rd = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [9:0]  e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_port  = 2'd0;
            prev_acked = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            nv = int'(loc_valid) + int'(x_valid) + int'(y_valid);
            chk("valid_onehot", nv <= 1, 1);
            port = loc_valid ? 2'd1 : x_valid ? 2'd2 : y_valid ? 2'd3 : 2'd0;
            if (prev_acked) chk("gap_after_ack", nv, 0);
            if (nv != 0 && prev_port == 2'd0) chk("rd_to_valid", cyc - rd_cyc, 2);
            if (nv != 0 && prev_port != 2'd0 && !prev_acked) begin
                chk("hold_port", port, prev_port);
                chk("hold_data", out_data, prev_data);
            end
            acked = (port == 2'd1 && loc_ack) || (port == 2'd2 && x_ack) || (port == 2'd3 && y_ack);
            if (acked) begin
                if (exq.size() == 0) chk("unexpected_flit", {port, out_data}, 0);
                else begin
                    e = exq.pop_front();
                    chk("flit", {port, out_data}, e);
                end
            end
            if (drop) begin
                if (exq.size() == 0) chk("unexpected_drop", {2'd0, fifo_data}, 10'h3ff);
                else begin
                    e = exq.pop_front();
                    chk("drop", {2'd0, fifo_data}, e);
                end
            end
            if (fifo_rd) begin
                chk("rd_pulse", prev_rd, 0);
                chk("rd_when_empty", fifo_empty, 0);
                if (fq.size() != 0) fifo_data = fq.pop_front();
                rd_cyc = cyc;
                fifo_empty = (fq.size() == 0);
            end
            prev_rd    = fifo_rd;
            prev_port  = port;
            prev_acked = acked;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (rnd) begin
                loc_ack = 1'($urandom_range(0, 1));
                x_ack   = 1'($urandom_range(0, 1));
                y_ack   = 1'($urandom_range(0, 1));
            end
            tick();
            done = (exq.size() == 0) && (fq.size() == 0) && !busy && !fifo_rd;
        end
        chk("drain_timeout", done, 1);
        loc_ack = 1'b1;
        x_ack   = 1'b1;
        y_ack   = 1'b1;
    endtask

    task automatic wait_x_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = x_valid;
        end
        chk("x_valid_timeout", seen, 1);
    endtask

    logic [7:0] h;
    logic [2:0] len;

    initial begin
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_data = 8'h00;
        loc_ack = 1'b0;
        x_ack = 1'b0;
        y_ack = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {fifo_rd, loc_valid, x_valid, y_valid, busy, drop, out_data}, 0);
        rst = 1'b0;
        loc_ack = 1'b1;
        x_ack = 1'b1;
        y_ack = 1'b1;
        tick();

        // single-flit packet to local
        push(2'd1, 8'h80);
        drain(1'b0);
        chk("busy_after_80", busy, 0);

        // two-body packet to y
        push(2'd3, 8'hA1);
        push(2'd3, 8'h11);
        push(2'd3, 8'h22);
        drain(1'b0);
        chk("busy_after_A1", busy, 0);

        // x port stalled for 5 cycles; body with bit7 set is still a body
        x_ack = 1'b0;
        push(2'd2, 8'h92);
        push(2'd2, 8'hC3);
        wait_x_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_x_valid", x_valid, 1);
            chk("stall_data", out_data, 8'h92);
            chk("stall_no_rd", fifo_rd, 0);
            tick();
        end
        x_ack = 1'b1;
        drain(1'b0);

        // stray body outside a packet is dropped, next header routes normally
        push(2'd0, 8'h05);
        push(2'd1, 8'h80);
        drain(1'b0);

        // FIFO runs dry mid-packet
        push(2'd1, 8'hB0);
        push(2'd1, 8'h44);
        repeat (20) tick();
        chk("dry_busy", busy, 1);
        chk("dry_valids", {loc_valid, x_valid, y_valid}, 0);
        chk("dry_flits_left", exq.size(), 0);
        push(2'd1, 8'h55);
        push(2'd1, 8'hE6);
        drain(1'b0);
        chk("busy_after_B0", busy, 0);

        // asynchronous reset while x_valid is up
        x_ack = 1'b0;
        push(2'd2, 8'h92);
        push(2'd2, 8'h33);
        wait_x_valid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_x_valid", x_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        fq.delete();
        exq.delete();
        fifo_empty = 1'b1;
        tick();
        rst = 1'b0;
        x_ack = 1'b1;
        push(2'd3, 8'h81);
        drain(1'b0);

        // maximum length, then random packets with random acks
        push(2'd2, 8'hF3);
        for (int b = 0; b < 7; b++) push(2'd2, 8'($urandom));
        drain(1'b1);
        for (int k = 0; k < 6; k++) begin
            len = 3'($urandom_range(0, 7));
            h = {1'b1, len, 2'($urandom), 2'($urandom)};
            push(rt(h), h);
            for (int b = 0; b < int'(len); b++) push(rt(h), 8'($urandom));
            drain(1'b1);
        end
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
